ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Shares the single external SRAM between instruction fetch (IF, read-only) and the MEM stage
//  (read/write, write data from the RAM data mux). Arbitrates the two requesters and sequences
//  the SRAM strobes (CE/OE/WE) with setup/pulse/hold timing. Returns read data with a one-cycle ack.
//  Sits between the pipeline and the top-level SRAM pads; the tristate buffer is at top level.
// PARAMETERS
//  DATA_W     16  data bus width (matches `DATA_BUS)
//  ADDR_W     16  address bus width (matches `ADDR_BUS)
//  RD_CYCLES  1   cycles oe_n is held low per read (>=1)
//  WR_CYCLES  2   cycles we_n is held low per write (>=1)
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous reset, active-low
//  if_req        in   1       IF read request, held until if_ack
//  if_addr       in   ADDR_W  IF read address
//  if_rdata      out  DATA_W  IF read data, valid while if_ack=1
//  if_ack        out  1       one-cycle pulse: IF access complete
//  mem_req       in   1       MEM request, held until mem_ack
//  mem_we        in   1       1=write, 0=read
//  mem_addr      in   ADDR_W  MEM address
//  mem_wdata     in   DATA_W  MEM write data
//  mem_rdata     out  DATA_W  MEM read data, valid while mem_ack=1
//  mem_ack       out  1       one-cycle pulse: MEM access complete
//  busy          out  1       1 when state != IDLE
//  ram_addr      out  ADDR_W  SRAM address
//  ram_wdata     out  DATA_W  SRAM write data
//  ram_wdata_oe  out  1       drive enable for the SRAM data tristate
//  ram_rdata     in   DATA_W  SRAM read data from the pads
//  ram_ce_n, ram_oe_n, ram_we_n   out  1 each  SRAM strobes, active-low
// BEHAVIOUR
//  - Reset (async, rst=0): state=IDLE; ce_n/oe_n/we_n=1; wdata_oe=0; acks=0; addr/wdata/rdata outs=0.
//    Reset mid-access aborts it at once and no ack is issued. last_grant=IF.
//  - All outputs are registered. FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.
//  - IDLE arbitration, same cycle as the request:
//    - A requester whose ack is high this cycle is ignored (its req is stale).
//    - Only one eligible requester: it is granted.
//    - Both eligible: grant the one not in last_grant, so the first tie after reset goes to MEM.
//    - The grant updates last_grant and latches addr, we and wdata. Later input changes are ignored.
//  - READ: ce_n=0, oe_n=0 for RD_CYCLES cycles. At the edge ending the last cycle:
//    - ram_rdata is captured into the owner's rdata and its ack is set for 1 cycle;
//    - ce_n/oe_n return to 1 and the state goes to IDLE.
//    - Request-to-ack latency = RD_CYCLES+1 cycles.
//  - WRITE sequence:
//    - WR_SETUP (1 cycle): ce_n=0, wdata_oe=1, we_n=1.
//    - WR_PULSE (WR_CYCLES cycles): we_n=0.
//    - WR_HOLD (1 cycle): we_n=1, data and address still driven.
//    - Then mem_ack=1 for 1 cycle, ce_n=1, wdata_oe=0, state IDLE.
//    - Latency = WR_CYCLES+3.
//  - oe_n and wdata_oe are never 0/1 together. we_n never falls in the cycle the address changes.
//  - An IF request with mem_we does not exist; IF is always a read.
//  - A cycle counter of width clog2(max(RD,WR)_CYCLES)+1 counts down within READ/WR_PULSE.
//  - The next access may be granted in the ack cycle (IDLE), so back-to-back accesses have no gap.
// STRUCTURE
//  - define.v additions: `RAM_ST_BUS and `RAM_ST_IDLE/READ/WR_SETUP/WR_PULSE/WR_HOLD;
//    `RAM_GRANT_IF/MEM. Reuse `DATA_BUS/`ADDR_BUS.
//  - One sub-module: ram_grant_arbiter, a 2-way round-robin grant with last_grant register.
//    The rest is a single FSM plus counter.
// TESTING
//  1. Reset asserted during WR_PULSE:
//     -> ram_we_n=1, ram_wdata_oe=0 with no clock edge; mem_ack never pulses; busy=0.
//  2. IF read of 0x0040, ram_rdata=0x1234, RD_CYCLES=1:
//     -> oe_n=0 exactly 1 cycle; if_ack at cycle 2 with if_rdata=0x1234.
//  3. MEM write 0xBF01 to 0x8000, WR_CYCLES=2:
//     -> we_n low exactly 2 cycles; wdata_oe high 4 cycles; mem_ack at cycle 5.
//  4. Both req after reset, each held to ack and re-raised:
//     -> grant order MEM, IF, MEM, IF; no cycle with both acks.
//  5. Requester keeps req high through its ack cycle, other idle:
//     -> no duplicate grant; busy=0 the cycle after ack.
//  6. mem_wdata/mem_addr changed mid-write:
//     -> ram_wdata/ram_addr keep the latched 0xBF01/0x8000 through WR_HOLD.

Source files
------------

// File: rtl/ram_access_arbiter_pkg.sv
// ram_access_arbiter_pkg: shared types and sizing helpers for the SRAM access arbiter
package ram_access_arbiter_pkg;
  localparam int RAM_DATA_W = 16;
  localparam int RAM_ADDR_W = 16;
  typedef enum logic [2:0] {
    RAM_ST_IDLE,
    RAM_ST_READ,
    RAM_ST_WR_SETUP,
    RAM_ST_WR_PULSE,
    RAM_ST_WR_HOLD
  } ram_st_e;
  typedef enum logic {
    RAM_GRANT_IF,
    RAM_GRANT_MEM
  } ram_grant_e;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ram_grant_arbiter.sv
// ram_grant_arbiter: 2-way round-robin grant between IF and MEM with a last_grant register
module ram_grant_arbiter
  import ram_access_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_req_if,
  input  logic       i_req_mem,
  output logic       o_vld,
  output ram_grant_e o_grant
);
  ram_grant_e r_last;
  // a tie goes to whoever was not served last; a lone requester always wins
  always_comb begin
    o_vld   = i_en && (i_req_if || i_req_mem);
    o_grant = (i_req_if && i_req_mem) ? ((r_last == RAM_GRANT_IF) ? RAM_GRANT_MEM : RAM_GRANT_IF)
            : (i_req_mem ? RAM_GRANT_MEM : RAM_GRANT_IF);
  end
  // remember the most recent winner; reset makes the first tie go to MEM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_last <= RAM_GRANT_IF;
    else if (o_vld) r_last <= o_grant;
  end
endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one SRAM between IF reads and MEM reads/writes with timed strobes
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int DATA_W    = RAM_DATA_W,
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int RD_CYCLES = 1,
  parameter int WR_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ack,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_wdata_oe,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_ram_ce_n,
  output logic              o_ram_oe_n,
  output logic              o_ram_we_n
);
  localparam int CNT_W = $clog2(max_int(RD_CYCLES, WR_CYCLES)) + 1;
  ram_st_e           r_state, w_state_nxt;
  ram_grant_e        r_owner, w_owner_nxt, w_gnt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_gnt_vld, w_gnt_wr;
  logic              w_ce_n, w_oe_n, w_we_n, w_wdata_oe, w_if_ack, w_mem_ack;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, w_if_rdata, w_mem_rdata;
  logic              r_ce_n, r_oe_n, r_we_n, r_wdata_oe, r_if_ack, r_mem_ack, r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_mem_rdata;

  ram_grant_arbiter u_grant (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (r_state == RAM_ST_IDLE),
    .i_req_if (i_if_req && !r_if_ack),
    .i_req_mem(i_mem_req && !r_mem_ack),
    .o_vld    (w_gnt_vld),
    .o_grant  (w_gnt)
  );

  assign w_gnt_wr = (w_gnt == RAM_GRANT_MEM) && i_mem_we;

  // next state plus the next value of every registered output
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_ce_n      = 1'b1;
    w_oe_n      = 1'b1;
    w_we_n      = 1'b1;
    w_wdata_oe  = 1'b0;
    w_if_ack    = 1'b0;
    w_mem_ack   = 1'b0;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_if_rdata  = r_if_rdata;
    w_mem_rdata = r_mem_rdata;
    case (r_state)
      RAM_ST_IDLE: begin
        if (w_gnt_vld) begin
          w_owner_nxt = w_gnt;
          w_ce_n      = 1'b0;
          w_addr      = (w_gnt == RAM_GRANT_MEM) ? i_mem_addr : i_if_addr;
          w_wdata     = w_gnt_wr ? i_mem_wdata : r_wdata;
          w_wdata_oe  = w_gnt_wr;
          w_oe_n      = w_gnt_wr;
          w_cnt_nxt   = CNT_W'(RD_CYCLES - 1);
          w_state_nxt = w_gnt_wr ? RAM_ST_WR_SETUP : RAM_ST_READ;
        end
      end
      RAM_ST_READ: begin
        if (r_cnt == '0) begin
          w_state_nxt = RAM_ST_IDLE;
          w_if_ack    = (r_owner == RAM_GRANT_IF);
          w_mem_ack   = (r_owner == RAM_GRANT_MEM);
          w_if_rdata  = (r_owner == RAM_GRANT_IF) ? i_ram_rdata : r_if_rdata;
          w_mem_rdata = (r_owner == RAM_GRANT_MEM) ? i_ram_rdata : r_mem_rdata;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          w_ce_n    = 1'b0;
          w_oe_n    = 1'b0;
        end
      end
      RAM_ST_WR_SETUP: begin
        w_state_nxt = RAM_ST_WR_PULSE;
        w_cnt_nxt   = CNT_W'(WR_CYCLES - 1);
        w_ce_n      = 1'b0;
        w_wdata_oe  = 1'b1;
        w_we_n      = 1'b0;
      end
      RAM_ST_WR_PULSE: begin
        w_ce_n      = 1'b0;
        w_wdata_oe  = 1'b1;
        w_we_n      = (r_cnt == '0);
        w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - CNT_W'(1);
        w_state_nxt = (r_cnt == '0) ? RAM_ST_WR_HOLD : RAM_ST_WR_PULSE;
      end
      RAM_ST_WR_HOLD: begin
        w_state_nxt = RAM_ST_IDLE;
        w_mem_ack   = 1'b1;
      end
      default: w_state_nxt = RAM_ST_IDLE;
    endcase
  end

  // FSM state, owner and strobe-length counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RAM_ST_IDLE;
      r_owner <= RAM_GRANT_IF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // every output is a flop so the SRAM pads see glitch-free strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_wdata_oe  <= 1'b0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_busy      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_ce_n      <= w_ce_n;
      r_oe_n      <= w_oe_n;
      r_we_n      <= w_we_n;
      r_wdata_oe  <= w_wdata_oe;
      r_if_ack    <= w_if_ack;
      r_mem_ack   <= w_mem_ack;
      r_busy      <= (w_state_nxt != RAM_ST_IDLE);
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_if_rdata  <= w_if_rdata;
      r_mem_rdata <= w_mem_rdata;
    end
  end

  assign o_ram_ce_n     = r_ce_n;
  assign o_ram_oe_n     = r_oe_n;
  assign o_ram_we_n     = r_we_n;
  assign o_ram_wdata_oe = r_wdata_oe;
  assign o_if_ack       = r_if_ack;
  assign o_mem_ack      = r_mem_ack;
  assign o_busy         = r_busy;
  assign o_ram_addr     = r_addr;
  assign o_ram_wdata    = r_wdata;
  assign o_if_rdata     = r_if_rdata;
  assign o_mem_rdata    = r_mem_rdata;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed checks of arbitration, strobe timing, latching and reset abort
module tb_ram_access_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, mem_req, mem_we;
  logic [15:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [15:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ack, mem_ack, busy, ram_wdata_oe, ram_ce_n, ram_oe_n, ram_we_n;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] we_mask, oe_mask, if_mask, mem_mask;
  int          conflicts, both_acks, stray_acks;

  ram_access_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_CYCLES(1), .WR_CYCLES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ack(if_ack),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata), .o_mem_ack(mem_ack), .o_busy(busy),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_wdata_oe(ram_wdata_oe),
    .i_ram_rdata(ram_rdata), .o_ram_ce_n(ram_ce_n), .o_ram_oe_n(ram_oe_n), .o_ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; ram_rdata = 0;
    step(); step();
    chk("rst_ce_n", ram_ce_n, 1); chk("rst_oe_n", ram_oe_n, 1); chk("rst_we_n", ram_we_n, 1);
    chk("rst_wdata_oe", ram_wdata_oe, 0); chk("rst_acks", {if_ack, mem_ack}, 0);
    chk("rst_busy", busy, 0); chk("rst_addr", ram_addr, 0); chk("rst_rdata", {if_rdata, mem_rdata}, 0);
    rst_n = 1'b1;
    step();
    // IF read of 0x0040
    if_req = 1; if_addr = 16'h0040; ram_rdata = 16'h1234;
    step();
    chk("rd_c1_oe_n", ram_oe_n, 0); chk("rd_c1_ce_n", ram_ce_n, 0); chk("rd_c1_addr", ram_addr, 16'h0040);
    chk("rd_c1_busy", busy, 1); chk("rd_c1_ack", if_ack, 0); chk("rd_c1_wdata_oe", ram_wdata_oe, 0);
    step();
    chk("rd_c2_ack", if_ack, 1); chk("rd_c2_rdata", if_rdata, 16'h1234); chk("rd_c2_oe_n", ram_oe_n, 1);
    chk("rd_c2_mem_ack", mem_ack, 0);
    if_req = 0;
    step();
    chk("rd_c3_ack", if_ack, 0); chk("rd_c3_busy", busy, 0);
    // MEM write 0xBF01 to 0x8000, inputs disturbed mid-write
    mem_req = 1; mem_we = 1; mem_addr = 16'h8000; mem_wdata = 16'hBF01;
    we_mask = 0; oe_mask = 0; mem_mask = 0; conflicts = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (!ram_we_n) we_mask[c] = 1'b1;
      if (ram_wdata_oe) oe_mask[c] = 1'b1;
      if (mem_ack) mem_mask[c] = 1'b1;
      if (ram_wdata_oe && !ram_oe_n) conflicts++;
      if (c <= 4) begin
        chk($sformatf("wr_c%0d_addr", c), ram_addr, 16'h8000);
        chk($sformatf("wr_c%0d_wdata", c), ram_wdata, 16'hBF01);
      end
      if (c == 2) begin mem_addr = 16'h1111; mem_wdata = 16'hFFFF; end
      if (c == 5) mem_req = 0;
    end
    chk("wr_we_mask", we_mask, 16'h000C); chk("wr_oe_mask", oe_mask, 16'h001E);
    chk("wr_ack_mask", mem_mask, 16'h0020); chk("wr_oe_conflict", conflicts, 0);
    chk("wr_c6_busy", busy, 0);
    // requester keeps req high through its ack cycle
    if_req = 1; if_addr = 16'h0077; ram_rdata = 16'h00C3;
    step(); chk("hold_c1_busy", busy, 1);
    step(); chk("hold_c2_ack", if_ack, 1); chk("hold_c2_busy", busy, 0); chk("hold_c2_rdata", if_rdata, 16'h00C3);
    step(); chk("hold_c3_busy", busy, 0); chk("hold_c3_ack", if_ack, 0); chk("hold_c3_ce_n", ram_ce_n, 1);
    if_req = 0;
    step(); chk("hold_c4_busy", busy, 0); chk("hold_c4_ack", if_ack, 0);
    // reset asserted during WR_PULSE
    mem_req = 1; mem_we = 1; mem_addr = 16'h0010; mem_wdata = 16'h5555;
    step(); chk("abort_c1_setup_we_n", ram_we_n, 1);
    step(); chk("abort_c2_we_n", ram_we_n, 0); chk("abort_c2_wdata_oe", ram_wdata_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_n", ram_we_n, 1); chk("abort_wdata_oe", ram_wdata_oe, 0);
    chk("abort_busy", busy, 0); chk("abort_ce_n", ram_ce_n, 1);
    mem_req = 0; mem_we = 0;
    stray_acks = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (mem_ack) stray_acks++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (mem_ack) stray_acks++;
    end
    chk("abort_no_ack", stray_acks, 0);
    // both requesting after reset: MEM, IF, MEM, IF
    if_req = 1; if_addr = 16'h0100; mem_req = 1; mem_we = 0; mem_addr = 16'h0200; ram_rdata = 16'hA5A5;
    if_mask = 0; mem_mask = 0; both_acks = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (if_ack) if_mask[c] = 1'b1;
      if (mem_ack) mem_mask[c] = 1'b1;
      if (if_ack && mem_ack) both_acks++;
      if (c == 1) chk("rr_first_addr", ram_addr, 16'h0200);
      if (c == 2) chk("rr_mem_rdata", mem_rdata, 16'hA5A5);
      if (c == 8) begin if_req = 0; mem_req = 0; end
    end
    chk("rr_mem_acks", mem_mask, 16'h0044); chk("rr_if_acks", if_mask, 16'h0110);
    chk("rr_both_acks", both_acks, 0); chk("rr_end_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
